uart_rx_ctrl: RTL and testbench

//  Sequencing controller for the UART receive datapath (external RSR shift register + RDR holding register).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and
// oversampling constants used by the RX/TX controllers.
package uart_pkg;

    localparam int OVS           = 8;
    localparam int MAX_DATA_BITS = 9;

    localparam logic [2:0] MID_SAMPLE  = 3'd3;
    localparam logic [2:0] LAST_SAMPLE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous line that idles high.
// Reset drives both stages to 1 so a released reset never looks like a start.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start validation, mid-bit sampling,
// RSR shift / RDR load strobes, parity/stop checks and RDR occupancy.
import uart_pkg::*;

module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic bclkx8,
    input  logic rst,
    input  logic rxd,
    input  logic rd_ack,
    input  logic err_clr,
    output logic shft_rsr,
    output logic rx_bit,
    output logic load_rdr,
    output logic rdr_full,
    output logic busy,
    output logic frame_err,
    output logic parity_err,
    output logic overrun_err
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic       ODD      = (PARITY_ODD != 0);

    logic   w_rxd_s;

    state_t r_state, w_state;
    logic [2:0] r_ct1, w_ct1;
    logic [3:0] r_ct2, w_ct2;
    logic   r_acc, w_acc;
    logic   r_pbad, w_pbad;
    logic   r_shft, w_shft;
    logic   r_bit, w_bit;
    logic   r_load, w_load;
    logic   r_full, w_full;
    logic   r_busy, w_busy;
    logic   r_fe, w_fe;
    logic   r_pe, w_pe;
    logic   r_ov, w_ov;
    logic   w_set_fe, w_set_pe, w_set_ov;

    uart_sync2 u_sync (
        .i_clk (bclkx8),
        .i_rst (rst),
        .i_d   (rxd),
        .o_q   (w_rxd_s)
    );

    // State, counters, flags and registered strobes
    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ct1   <= 3'd0;
            r_ct2   <= 4'd0;
            r_acc   <= 1'b0;
            r_pbad  <= 1'b0;
            r_shft  <= 1'b0;
            r_bit   <= 1'b0;
            r_load  <= 1'b0;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ct1   <= w_ct1;
            r_ct2   <= w_ct2;
            r_acc   <= w_acc;
            r_pbad  <= w_pbad;
            r_shft  <= w_shft;
            r_bit   <= w_bit;
            r_load  <= w_load;
            r_full  <= w_full;
            r_busy  <= w_busy;
            r_fe    <= w_fe;
            r_pe    <= w_pe;
            r_ov    <= w_ov;
        end
    end

    // Next-state, counter, strobe and flag logic
    always_comb begin
        w_state  = r_state;
        w_ct1    = r_ct1;
        w_ct2    = r_ct2;
        w_acc    = r_acc;
        w_pbad   = r_pbad;
        w_shft   = 1'b0;
        w_bit    = r_bit;
        w_load   = 1'b0;
        w_full   = r_full;
        w_fe     = r_fe;
        w_pe     = r_pe;
        w_ov     = r_ov;
        w_set_fe = 1'b0;
        w_set_pe = 1'b0;
        w_set_ov = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_rxd_s) begin
                    w_state = ST_START;
                    w_ct1   = 3'd0;
                end
            end
            ST_START: begin
                if (w_rxd_s) begin
                    w_state = ST_IDLE;
                end else if (r_ct1 == MID_SAMPLE) begin
                    w_state = ST_DATA;
                    w_ct1   = 3'd0;
                    w_ct2   = 4'd0;
                    w_acc   = 1'b0;
                    w_pbad  = 1'b0;
                end else begin
                    w_ct1 = r_ct1 + 3'd1;
                end
            end
            ST_DATA: begin
                w_ct1 = r_ct1 + 3'd1;
                if (r_ct1 == LAST_SAMPLE) begin
                    w_shft = 1'b1;
                    w_bit  = w_rxd_s;
                    w_acc  = r_acc ^ w_rxd_s;
                    w_ct2  = r_ct2 + 4'd1;
                    if (r_ct2 == LAST_BIT) begin
                        w_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                w_ct1 = r_ct1 + 3'd1;
                if (r_ct1 == LAST_SAMPLE) begin
                    w_pbad  = r_acc ^ w_rxd_s ^ ODD;
                    w_state = ST_STOP;
                end
            end
            ST_STOP: begin
                w_ct1 = r_ct1 + 3'd1;
                if (r_ct1 == LAST_SAMPLE) begin
                    w_state  = ST_IDLE;
                    w_set_fe = !w_rxd_s;
                    w_set_pe = r_pbad;
                    if (w_rxd_s && !r_pbad) begin
                        if (r_full && !rd_ack) begin
                            w_set_ov = 1'b1;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // A host read frees the RDR; a same-cycle load keeps it occupied
        if (rd_ack) begin
            w_full = 1'b0;
        end
        if (w_load) begin
            w_full = 1'b1;
        end

        // Clearing loses to a freshly detected error
        if (err_clr) begin
            w_fe = 1'b0;
            w_pe = 1'b0;
            w_ov = 1'b0;
        end
        if (w_set_fe) begin
            w_fe = 1'b1;
        end
        if (w_set_pe) begin
            w_pe = 1'b1;
        end
        if (w_set_ov) begin
            w_ov = 1'b1;
        end

        w_busy = (w_state != ST_IDLE);
    end

    assign shft_rsr    = r_shft;
    assign rx_bit      = r_bit;
    assign load_rdr    = r_load;
    assign rdr_full    = r_full;
    assign busy        = r_busy;
    assign frame_err   = r_fe;
    assign parity_err  = r_pe;
    assign overrun_err = r_ov;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 and an 8E1 instance driven with
// directed and random frames, checked against a frame-level model.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rxd;
    logic [1:0] ack;
    logic [1:0] clr;
    logic [1:0] shft, rbit, load, full, busy, fe, pe, ov;

    int n_cmp = 0;
    int n_bad = 0;

    int         n_sh   [2] = '{0, 0};
    int         n_ld   [2] = '{0, 0};
    int         n_bz   [2] = '{0, 0};
    logic [7:0] sh_reg [2] = '{8'h00, 8'h00};

    logic m_full [2] = '{1'b0, 1'b0};
    logic m_fe   [2] = '{1'b0, 1'b0};
    logic m_pe   [2] = '{1'b0, 1'b0};
    logic m_ov   [2] = '{1'b0, 1'b0};
    int   m_ld   [2] = '{0, 0};

    always #5 clk = ~clk;

    // Instance 0: 8N1, instance 1: 8 data bits + even parity
    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_rx_ctrl #(
            .DATA_BITS  (8),
            .PARITY_EN  (g),
            .PARITY_ODD (0)
        ) u_dut (
            .bclkx8      (clk),
            .rst         (rst),
            .rxd         (rxd[g]),
            .rd_ack      (ack[g]),
            .err_clr     (clr[g]),
            .shft_rsr    (shft[g]),
            .rx_bit      (rbit[g]),
            .load_rdr    (load[g]),
            .rdr_full    (full[g]),
            .busy        (busy[g]),
            .frame_err   (fe[g]),
            .parity_err  (pe[g]),
            .overrun_err (ov[g])
        );
    end

    // Count strobes and collect shifted bits, sampled mid-cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (shft[d]) begin
                n_sh[d]   <= n_sh[d] + 1;
                sh_reg[d] <= {rbit[d], sh_reg[d][7:1]};
            end
            if (load[d]) n_ld[d] <= n_ld[d] + 1;
            if (busy[d]) n_bz[d] <= n_bz[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs(input int d);
        return {shft[d], rbit[d], load[d], full[d],
                busy[d], fe[d], pe[d], ov[d]};
    endfunction

    task automatic chk_flags(input string tag, input int d);
        chk({tag, "_nload"}, n_ld[d], m_ld[d]);
        chk({tag, "_full"}, full[d], m_full[d]);
        chk({tag, "_ferr"}, fe[d], m_fe[d]);
        chk({tag, "_perr"}, pe[d], m_pe[d]);
        chk({tag, "_oerr"}, ov[d], m_ov[d]);
    endtask

    // One frame of 8 cycles per bit; ack/clr optionally pulsed on the
    // cycle the stop bit is judged (10th/11th bit centre).
    task automatic send_frame(input string tag, input int d,
                              input logic [7:0] data, input logic pbit,
                              input logic sbit, input logic ack_ld,
                              input logic clr_ld);
        logic [10:0] fr;
        int          nb;
        int          dec;
        int          sh0;
        logic        par_ok;
        nb  = 10 + d;
        dec = 78 + 8 * d;
        sh0 = n_sh[d];
        fr  = '1;
        fr[0]   = 1'b0;
        fr[8:1] = data;
        if (d == 1) begin
            fr[9]  = pbit;
            fr[10] = sbit;
        end else begin
            fr[9] = sbit;
        end
        for (int c = 0; c < 8 * nb; c++) begin
            @(negedge clk);
            rxd[d] = fr[c / 8];
            ack[d] = ack_ld && (c == dec);
            clr[d] = clr_ld && (c == dec);
        end
        @(negedge clk);
        rxd[d] = 1'b1;
        ack[d] = 1'b0;
        clr[d] = 1'b0;

        par_ok = (d == 0) || ((^data ^ pbit) == 1'b0);
        if (clr_ld) begin
            m_fe[d] = 1'b0;
            m_pe[d] = 1'b0;
            m_ov[d] = 1'b0;
        end
        if (!sbit) m_fe[d] = 1'b1;
        if (!par_ok) m_pe[d] = 1'b1;
        if (sbit && par_ok) begin
            if (m_full[d] && !ack_ld) begin
                m_ov[d] = 1'b1;
            end else begin
                m_ld[d]++;
                m_full[d] = 1'b1;
            end
        end else if (ack_ld) begin
            m_full[d] = 1'b0;
        end

        chk({tag, "_nshift"}, n_sh[d] - sh0, 8);
        chk({tag, "_data"}, sh_reg[d], data);
        chk_flags(tag, d);
    endtask

    task automatic pulse_ack(input int d);
        @(negedge clk);
        ack[d] = 1'b1;
        @(negedge clk);
        ack[d] = 1'b0;
        m_full[d] = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        @(negedge clk);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0;
        m_fe[d] = 1'b0;
        m_pe[d] = 1'b0;
        m_ov[d] = 1'b0;
    endtask

    initial begin
        int         bz0, sh0, ld0, db, d;
        logic [7:0] data;
        logic       pbit, sbit, ackl, clrl;

        rst = 1'b1;
        rxd = 2'b11;
        ack = 2'b00;
        clr = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_outs0", outs(0), 8'h00);
        chk("reset_outs1", outs(1), 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_outs0", outs(0), 8'h00);
        chk("idle_outs1", outs(1), 8'h00);

        // Basic 8N1 frame, then host read
        send_frame("a5", 0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_ack(0);
        chk("a5_read_full", full[0], 1'b0);

        // Short low glitch must be rejected
        bz0 = n_bz[0];
        sh0 = n_sh[0];
        ld0 = n_ld[0];
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (2) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (10) @(negedge clk);
        db = n_bz[0] - bz0;
        chk("glitch_busy_2to3", (db >= 2 && db <= 3) ? 1 : 0, 1);
        chk("glitch_nshift", n_sh[0] - sh0, 0);
        chk("glitch_nload", n_ld[0] - ld0, 0);
        chk("glitch_outs", outs(0) & 8'h1F, 8'h00);

        // Even parity violation, then clear
        send_frame("par07", 1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_clr(1);
        chk("par07_clr", pe[1], 1'b0);

        // Bad stop bit, then a good frame; frame_err is sticky
        send_frame("stop3c", 0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        send_frame("ok81", 0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_ack(0);
        pulse_clr(0);

        // Back-to-back without reading: overrun
        send_frame("b2b11", 0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame("b2b22", 0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_ack(0);
        pulse_clr(0);

        // Same, but read coincides with the second load
        send_frame("ack11", 0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame("ack22", 0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_ack(0);

        // Error arriving together with err_clr stays set
        send_frame("clrwin", 1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        pulse_clr(1);

        // Random frames on both instances
        for (int i = 0; i < 30; i++) begin
            d    = int'($urandom % 2);
            data = 8'($urandom);
            pbit = (^data) ^ ($urandom % 4 == 0);
            sbit = ($urandom % 6 != 0);
            ackl = ($urandom % 4 == 0);
            clrl = ($urandom % 5 == 0);
            send_frame($sformatf("rnd%0d", i), d, data, pbit, sbit,
                       ackl, clrl);
            if ($urandom % 2 == 0) pulse_ack(d);
            if ($urandom % 5 == 0) pulse_clr(d);
            repeat ($urandom % 4) @(negedge clk);
        end

        // Asynchronous reset in the middle of data bit 4
        pulse_ack(0);
        send_frame("prerst", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        data = 8'hC3;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            rxd[0] = (c < 8) ? 1'b0 : data[(c / 8) - 1];
        end
        chk("midrst_busy_before", busy[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_outs0", outs(0), 8'h00);
        chk("midrst_outs1", outs(1), 8'h00);
        @(negedge clk);
        rxd[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_fe[k]   = 1'b0;
            m_pe[k]   = 1'b0;
            m_ov[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        send_frame("post5a", 0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
